placar_truco_param: RTL and testbench
=====================================

PLACAR_TRUCO_PARAM -- requirements
Module: placar_truco_param

Interface
REQ-001 Parameter N_TIMES, default 2, number of teams (legal range 2..4).
REQ-002 Parameter PONTOS_MAX, default 12, points that close a hand (tento).
REQ-003 Parameter TENTOS_MAX, default 3, tentos that close the game.
REQ-004 Derived widths SHALL be: PW = $clog2(PONTOS_MAX+1); TW = $clog2(TENTOS_MAX+1); VW = max(1, $clog2(N_TIMES)).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port list:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  N_TIMES  point button per team, level, unsynchronised.
- btn_truco  input  1  raise-bet button, level.
- pontuacao  output  N_TIMES*PW  per-team hand score, team i at bits [i*PW +: PW].
- tentos  output  N_TIMES*TW  per-team tentos, team i at bits [i*TW +: TW].
- aposta  output  4  current hand value.
- vencedor  output  VW  index of the winning team, valid while jogo_encerrado=1.
- jogo_encerrado  output  1  game over.
- ocupado  output  1  high whenever FSM is not in INICIO.

Function
REQ-007 Each button SHALL pass a rising-edge detector (previous-sample register); a held button SHALL produce exactly one edge.
REQ-008 FSM states SHALL be INICIO, ADD, TENTO, COMPARA, FINAL.
REQ-009 INICIO: on any btn edge at clock k, capture the team index and go to ADD; pontuacao updates at clock k+1, visible from then.
REQ-010 Simultaneous btn edges: lowest team index wins; other edges dropped.
REQ-011 btn_truco edge in INICIO with no btn edge SHALL advance aposta 1->3->6->9->12; at 12 it SHALL stay 12.
REQ-012 btn_truco edge coincident with a btn edge SHALL be ignored; the point uses the current aposta.
REQ-013 Edges arriving outside INICIO SHALL be discarded, not queued.
REQ-014 ADD: score(team) <= min(score(team)+aposta, PONTOS_MAX), computed with one extra bit (no wrap); aposta <= 1; next = TENTO if the result equals PONTOS_MAX, else INICIO.
REQ-015 TENTO: tentos(team) += 1; all pontuacao cleared to 0; next = COMPARA.
REQ-016 COMPARA: if tentos(team) == TENTOS_MAX, set vencedor <= team and go to FINAL; else go to INICIO.
REQ-017 FINAL: jogo_encerrado = 1; all buttons ignored; only rst exits.
REQ-018 Tentos SHALL never exceed TENTOS_MAX; scores SHALL never exceed PONTOS_MAX.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL enter INICIO and set all pontuacao=0, tentos=0, aposta=1, vencedor=0, jogo_encerrado=0, ocupado=0, and edge-detector registers=0.
REQ-020 rst SHALL take priority in every state, including mid-ADD/TENTO; no partial update survives.
REQ-021 A button already high when rst falls SHALL NOT generate an edge.

Structure
REQ-022 Package placar_pkg SHALL hold estado_t, the aposta sequence constants, and a function returning the next aposta value.
REQ-023 Sub-module detector_borda, parameterised by width, SHALL implement REQ-007; it is instantiated once for {btn_truco, btn}.
REQ-024 Everything else SHALL be in one FSM/datapath module with registered outputs.

Verification (N_TIMES=2, defaults)
REQ-025 Reset -> all outputs 0, aposta=1, ocupado=0.
REQ-026 11 separate btn[0] pulses -> pontuacao0=11; 12th pulse -> tentos0=1, both scores=0, back in INICIO.
REQ-027 Two btn_truco pulses, then btn[1] -> aposta=6, then pontuacao1=6 and aposta returns to 1.
REQ-028 pontuacao0=8, five btn_truco pulses (aposta stays 12), then btn[0] -> score saturates to 12, tentos0 increments, scores cleared.
REQ-029 btn=2'b11 in the same cycle -> only team 0 gets +1; btn held 10 cycles -> single +1.
REQ-030 Team 1 reaches 3 tentos -> jogo_encerrado=1, vencedor=1, further presses ignored; rst asserted during ADD -> full reset values on the next clock.

Source files
------------

// File: rtl/placar_pkg.sv
// Shared types and bet-sequence helpers for the truco scoreboard.
package placar_pkg;

  typedef enum logic [2:0] {
    INICIO  = 3'd0,
    ADD     = 3'd1,
    TENTO   = 3'd2,
    COMPARA = 3'd3,
    FINAL   = 3'd4
  } estado_t;

  localparam logic [3:0] APOSTA_1  = 4'd1;
  localparam logic [3:0] APOSTA_3  = 4'd3;
  localparam logic [3:0] APOSTA_6  = 4'd6;
  localparam logic [3:0] APOSTA_9  = 4'd9;
  localparam logic [3:0] APOSTA_12 = 4'd12;

  // Bet ladder 1->3->6->9->12; the top value is sticky.
  function automatic logic [3:0] proxima_aposta(input logic [3:0] atual);
    case (atual)
      APOSTA_1: return APOSTA_3;
      APOSTA_3: return APOSTA_6;
      APOSTA_6: return APOSTA_9;
      APOSTA_9: return APOSTA_12;
      default:  return APOSTA_12;
    endcase
  endfunction

endpackage

// File: rtl/placar_truco_param_if.sv
// Button inputs and registered scoreboard outputs, plus FSM state for debug.
interface placar_truco_param_if #(
  parameter int N_TIMES    = 2,
  parameter int PONTOS_MAX = 12,
  parameter int TENTOS_MAX = 3
);
  import placar_pkg::*;

  localparam int PW = $clog2(PONTOS_MAX + 1);
  localparam int TW = $clog2(TENTOS_MAX + 1);
  localparam int VW = ($clog2(N_TIMES) > 1) ? $clog2(N_TIMES) : 1;

  // No valid/ready pair: buttons are levels and every rising edge is one
  // request. A request is accepted only while ocupado=0; edges seen while
  // ocupado=1 are dropped, never queued.
  logic [N_TIMES-1:0]    btn;
  logic                  btn_truco;
  logic [N_TIMES*PW-1:0] pontuacao;
  logic [N_TIMES*TW-1:0] tentos;
  logic [3:0]            aposta;
  logic [VW-1:0]         vencedor;
  logic                  jogo_encerrado;
  logic                  ocupado;
  estado_t               estado;

  modport master (
    output btn, btn_truco,
    input  pontuacao, tentos, aposta, vencedor, jogo_encerrado, ocupado, estado
  );

  modport slave (
    input  btn, btn_truco,
    output pontuacao, tentos, aposta, vencedor, jogo_encerrado, ocupado, estado
  );

endinterface

// File: rtl/detector_borda.sv
// Rising-edge detector; stays disarmed for the first cycle after reset so a
// button already held when reset falls never produces an edge.
module detector_borda #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] borda
);

  logic [W-1:0] prev;
  logic         armado;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      armado <= 1'b0;
    end else begin
      prev   <= din;
      armado <= 1'b1;
    end
  end

  assign borda = din & ~prev & {W{armado}};

endmodule

// File: rtl/placar_truco_param.sv
// Truco scoreboard: edge-detected buttons feed one FSM that adds the current
// bet to a team, closes tentos at PONTOS_MAX and the game at TENTOS_MAX.
module placar_truco_param
  import placar_pkg::*;
#(
  parameter int N_TIMES    = 2,
  parameter int PONTOS_MAX = 12,
  parameter int TENTOS_MAX = 3
) (
  input logic                clk,
  input logic                rst,
  placar_truco_param_if.slave bus
);

  localparam int PW = $clog2(PONTOS_MAX + 1);
  localparam int TW = $clog2(TENTOS_MAX + 1);
  localparam int VW = ($clog2(N_TIMES) > 1) ? $clog2(N_TIMES) : 1;
  localparam int SW = ((PW > 4) ? PW : 4) + 1;

  logic [N_TIMES:0]   bordas;
  logic [N_TIMES-1:0] borda_btn;
  logic               borda_truco;

  detector_borda #(.W(N_TIMES + 1)) u_borda (
    .clk   (clk),
    .rst   (rst),
    .din   ({bus.btn_truco, bus.btn}),
    .borda (bordas)
  );

  assign {borda_truco, borda_btn} = bordas;

  estado_t       estado, prox;
  logic [VW-1:0] time_r, time_sel;
  logic [PW-1:0] pontos   [N_TIMES];
  logic [TW-1:0] tentos_q [N_TIMES];
  logic [3:0]    aposta_q;
  logic [VW-1:0] vencedor_q;
  logic          encerrado_q;
  logic          ocupado_q;
  logic [SW-1:0] soma;
  logic [PW-1:0] pontos_sat;

  always_comb begin
    prox     = estado;
    time_sel = '0;
    // Scanning downward leaves the lowest pressed index selected.
    for (int i = N_TIMES - 1; i >= 0; i--) begin
      if (borda_btn[i]) time_sel = VW'(i);
    end
    soma       = SW'(pontos[time_r]) + SW'(aposta_q);
    pontos_sat = (soma >= SW'(PONTOS_MAX)) ? PW'(PONTOS_MAX) : soma[PW-1:0];
    case (estado)
      INICIO:  if (|borda_btn) prox = ADD;
      ADD:     prox = (pontos_sat == PW'(PONTOS_MAX)) ? TENTO : INICIO;
      TENTO:   prox = COMPARA;
      COMPARA: prox = (tentos_q[time_r] == TW'(TENTOS_MAX)) ? FINAL : INICIO;
      FINAL:   prox = FINAL;
      default: prox = INICIO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= INICIO;
      time_r      <= '0;
      aposta_q    <= APOSTA_1;
      vencedor_q  <= '0;
      encerrado_q <= 1'b0;
      ocupado_q   <= 1'b0;
      for (int i = 0; i < N_TIMES; i++) begin
        pontos[i]   <= '0;
        tentos_q[i] <= '0;
      end
    end else begin
      estado      <= prox;
      ocupado_q   <= (prox != INICIO);
      encerrado_q <= (prox == FINAL);
      case (estado)
        INICIO: begin
          if (|borda_btn) time_r <= time_sel;
          else if (borda_truco) aposta_q <= proxima_aposta(aposta_q);
        end
        ADD: begin
          pontos[time_r] <= pontos_sat;
          aposta_q       <= APOSTA_1;
        end
        TENTO: begin
          if (tentos_q[time_r] < TW'(TENTOS_MAX))
            tentos_q[time_r] <= tentos_q[time_r] + TW'(1);
          for (int i = 0; i < N_TIMES; i++) pontos[i] <= '0;
        end
        COMPARA: begin
          if (prox == FINAL) vencedor_q <= time_r;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_TIMES; g++) begin : g_saida
    assign bus.pontuacao[g*PW +: PW] = pontos[g];
    assign bus.tentos[g*TW +: TW]    = tentos_q[g];
  end

  assign bus.aposta         = aposta_q;
  assign bus.vencedor       = vencedor_q;
  assign bus.jogo_encerrado = encerrado_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.estado         = estado;

endmodule

// File: tb/tb_placar_truco_param.sv
// Directed scoreboard bench for placar_truco_param with default parameters.
module tb_placar_truco_param;
  import placar_pkg::*;

  localparam int W = 18;

  logic clk = 1'b0;
  logic rst;

  placar_truco_param_if #(.N_TIMES(2), .PONTOS_MAX(12), .TENTOS_MAX(3)) bus ();

  placar_truco_param #(.N_TIMES(2), .PONTOS_MAX(12), .TENTOS_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] pk(input int p0, input int p1, input int t0,
                                      input int t1, input int ap, input int j, input int v);
    return {4'(p1), 4'(p0), 2'(t1), 2'(t0), 4'(ap), 1'(j), 1'(v)};
  endfunction

  task automatic push_exp(input int p0, input int p1, input int t0,
                          input int t1, input int ap, input int j, input int v);
    exp_q.push_back(pk(p0, p1, t0, t1, ap, j, v));
  endtask

  // Monitor: a snapshot is due when the FSM returns idle, enters TENTO,
  // ends the game, or the bet moves while idle.
  logic       prev_ocup = 1'b0;
  logic       prev_jogo = 1'b0;
  logic       prev_rst  = 1'b1;
  logic [3:0] prev_ap   = 4'd1;

  always @(negedge clk) begin
    logic         evt;
    logic [W-1:0] snap;
    logic [W-1:0] req;
    evt  = 1'b0;
    snap = {bus.pontuacao, bus.tentos, bus.aposta, bus.jogo_encerrado, bus.vencedor};
    if (!rst && !prev_rst)
      evt = (prev_ocup && !bus.ocupado) || (bus.jogo_encerrado && !prev_jogo) ||
            (bus.estado == TENTO) ||
            (!bus.ocupado && !prev_ocup && (bus.aposta != prev_ap));
    if (evt) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", snap);
      end else begin
        req = exp_q.pop_front();
        check("snapshot", 32'(snap), 32'(req));
      end
    end
    prev_ocup = bus.ocupado;
    prev_jogo = bus.jogo_encerrado;
    prev_ap   = bus.aposta;
    prev_rst  = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic press_mask(input logic [1:0] m, input logic tr);
    @(posedge clk);
    #1 bus.btn = m; bus.btn_truco = tr;
    @(posedge clk);
    #1 bus.btn = 2'b00; bus.btn_truco = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic press(input int t);
    press_mask(2'(1 << t), 1'b0);
  endtask

  task automatic truco();
    @(posedge clk);
    #1 bus.btn_truco = 1'b1;
    @(posedge clk);
    #1 bus.btn_truco = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic hold(input int t, input int n);
    @(posedge clk);
    #1 bus.btn[t] = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.btn[t] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // Raise the bet from 1 to 12 with the given scores/tentos unchanged.
  task automatic ramp(input int p0, input int p1, input int t0, input int t1);
    push_exp(p0, p1, t0, t1, 3, 0, 0);  truco();
    push_exp(p0, p1, t0, t1, 6, 0, 0);  truco();
    push_exp(p0, p1, t0, t1, 9, 0, 0);  truco();
    push_exp(p0, p1, t0, t1, 12, 0, 0); truco();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.btn       = 2'b00;
    bus.btn_truco = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pontuacao", 32'(bus.pontuacao), 32'h0);
    check("rst_tentos", 32'(bus.tentos), 32'h0);
    check("rst_aposta", 32'(bus.aposta), 32'd1);
    check("rst_vencedor", 32'(bus.vencedor), 32'h0);
    check("rst_encerrado", 32'(bus.jogo_encerrado), 32'h0);
    check("rst_ocupado", 32'(bus.ocupado), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Eleven single points, then the twelfth closes a tento.
    for (int i = 1; i <= 11; i++) begin
      push_exp(i, 0, 0, 0, 1, 0, 0);
      press(0);
    end
    push_exp(12, 0, 0, 0, 1, 0, 0);
    push_exp(0, 0, 1, 0, 1, 0, 0);
    press(0);
    check("idle_after_tento", 32'(bus.estado), 32'(INICIO));

    // Two bet raises then a point for team 1.
    push_exp(0, 0, 1, 0, 3, 0, 0); truco();
    push_exp(0, 0, 1, 0, 6, 0, 0); truco();
    push_exp(0, 6, 1, 0, 1, 0, 0); press(1);

    // Team 0 to 8, bet to 12 (fifth raise sticks), then saturating point.
    for (int i = 1; i <= 8; i++) begin
      push_exp(i, 6, 1, 0, 1, 0, 0);
      press(0);
    end
    ramp(8, 6, 1, 0);
    truco();
    check("aposta_sticky", 32'(bus.aposta), 32'd12);
    push_exp(12, 6, 1, 0, 1, 0, 0);
    push_exp(0, 0, 2, 0, 1, 0, 0);
    press(0);

    // Simultaneous presses, a long hold, and a bet edge with a point edge.
    push_exp(1, 0, 2, 0, 1, 0, 0); press_mask(2'b11, 1'b0);
    push_exp(1, 1, 2, 0, 1, 0, 0); hold(1, 10);
    push_exp(1, 2, 2, 0, 1, 0, 0); press_mask(2'b10, 1'b1);
    check("truco_ignored", 32'(bus.aposta), 32'd1);

    // Team 1 wins three tentos at bet 12.
    ramp(1, 2, 2, 0);
    push_exp(1, 12, 2, 0, 1, 0, 0);
    push_exp(0, 0, 2, 1, 1, 0, 0);
    press(1);
    ramp(0, 0, 2, 1);
    push_exp(0, 12, 2, 1, 1, 0, 0);
    push_exp(0, 0, 2, 2, 1, 0, 0);
    press(1);
    ramp(0, 0, 2, 2);
    push_exp(0, 12, 2, 2, 1, 0, 0);
    push_exp(0, 0, 2, 3, 1, 1, 1);
    press(1);
    check("final_encerrado", 32'(bus.jogo_encerrado), 32'd1);
    check("final_vencedor", 32'(bus.vencedor), 32'd1);
    press(0);
    press(1);
    truco();
    check("final_estado", 32'(bus.estado), 32'(FINAL));
    check("final_tentos", 32'(bus.tentos), 32'hE);
    check("final_pontuacao", 32'(bus.pontuacao), 32'h0);
    check("final_aposta", 32'(bus.aposta), 32'd1);

    // Reset from FINAL with a button held across the reset release.
    rst        = 1'b1;
    bus.btn[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_encerrado", 32'(bus.jogo_encerrado), 32'h0);
    check("rst2_tentos", 32'(bus.tentos), 32'h0);
    check("rst2_vencedor", 32'(bus.vencedor), 32'h0);
    check("rst2_ocupado", 32'(bus.ocupado), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_no_edge_pont", 32'(bus.pontuacao), 32'h0);
    check("held_no_edge_estado", 32'(bus.estado), 32'(INICIO));
    bus.btn[0] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset landing while the FSM is in ADD.
    push_exp(1, 0, 0, 0, 1, 0, 0); press(0);
    push_exp(1, 0, 0, 0, 3, 0, 0); truco();
    @(posedge clk);
    #1 bus.btn[0] = 1'b1;
    @(posedge clk);
    #1 bus.btn[0] = 1'b0;
    check("in_add", 32'(bus.estado), 32'(ADD));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_add_pontuacao", 32'(bus.pontuacao), 32'h0);
    check("rst_add_aposta", 32'(bus.aposta), 32'd1);
    check("rst_add_estado", 32'(bus.estado), 32'(INICIO));
    check("rst_add_ocupado", 32'(bus.ocupado), 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
